mips_wb_queue: RTL

MIPS_WB_QUEUE -- requirements
Module: mips_wb_queue

---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_wb_match.sv | 65 ++++++
 rtl/mips_wb_queue.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the MIPS write-back path.
//   REG_AW     : register-address width (32 architectural registers)
//   DATA_W     : register data width
//   wb_entry_t : one pending write-back {dr, data}
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int REG_AW = 5;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [REG_AW-1:0] dr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/mips_wb_match.sv
// -----------------------------------------------------------------------------
// mips_wb_match
// Single-source lookup into the write-back queue: reports whether any occupied
// slot targets the source register and, when forwarding is built in, returns
// the data of the youngest such slot.
// Build option: MIPS_WB_FWD_EN adds the slot_data input and the fwd output.
// Ports:
//   slot_valid : per-slot occupancy (physical slot order)
//   head       : physical index of the oldest slot
//   slot_dr    : per-slot destination register
//   slot_data  : per-slot data (MIPS_WB_FWD_EN only)
//   sr         : source register to look up; register 0 never hits
//   hit        : some occupied slot targets sr
//   fwd        : youngest matching data, 0 when no hit (MIPS_WB_FWD_EN only)
// -----------------------------------------------------------------------------
module mips_wb_match
   import mips_pkg::*;
#(
   parameter int AW    = REG_AW,
   parameter int DEPTH = 4
`ifdef MIPS_WB_FWD_EN
   ,
   parameter int DW    = DATA_W
`endif
) (
   input  logic [DEPTH-1:0]               slot_valid,
   input  logic [$clog2(DEPTH)-1:0]       head,
   input  logic [DEPTH-1:0][AW-1:0]       slot_dr,
`ifdef MIPS_WB_FWD_EN
   input  logic [DEPTH-1:0][DW-1:0]       slot_data,
   output logic [DW-1:0]                  fwd,
`endif
   input  logic [AW-1:0]                  sr,
   output logic                           hit
);

   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0] match_vec;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
         assign match_vec[gi] = slot_valid[gi] && (slot_dr[gi] == sr);
      end
   endgenerate

   assign hit = (sr != '0) && (|match_vec);

`ifdef MIPS_WB_FWD_EN
   // Walk the slots oldest-to-youngest starting at head; the last match wins,
   // which is the youngest pending write to sr.
   always_comb begin
      fwd = '0;
      for (int k = 0; k < DEPTH; k++) begin
         logic [PW-1:0] idx;
         idx = head + PW'(k);
         if (match_vec[idx] && (sr != '0)) begin
            fwd = slot_data[idx];
         end
      end
   end
`endif

endmodule

// File: rtl/mips_wb_queue.sv
// -----------------------------------------------------------------------------
// mips_wb_queue
// FIFO of pending register write-backs between the pipeline and the register
// bank, with a two-source scoreboard lookup (and optional forwarding).
// Build option: MIPS_WB_FWD_EN adds fwd1/fwd2 and the youngest-match data mux;
// without it hit1/hit2 act as a stall-only scoreboard.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   in_valid/ready   : producer handshake; in_dr/in_data the offered result
//   wb_stall         : holds the head entry back from the register bank
//   write, dr, wrData: register-bank write port (head entry, combinational)
//   sr1/sr2          : source registers to look up
//   hit1/hit2        : a pending entry targets sr1/sr2
//   fwd1/fwd2        : youngest pending data for sr1/sr2 (MIPS_WB_FWD_EN)
//   level            : number of occupied entries
// -----------------------------------------------------------------------------
module mips_wb_queue
   import mips_pkg::*;
#(
   parameter int DW    = DATA_W,
   parameter int AW    = REG_AW,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [AW-1:0]            in_dr,
   input  logic [DW-1:0]            in_data,
   input  logic                     wb_stall,
   output logic                     write,
   output logic [AW-1:0]            dr,
   output logic [DW-1:0]            wrData,
   input  logic [AW-1:0]            sr1,
   input  logic [AW-1:0]            sr2,
   output logic                     hit1,
   output logic                     hit2,
`ifdef MIPS_WB_FWD_EN
   output logic [DW-1:0]            fwd1,
   output logic [DW-1:0]            fwd2,
`endif
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [PW-1:0] head_reg, head_next;
   logic [PW-1:0] tail_reg, tail_next;
   logic [LW-1:0] level_reg, level_next;
   logic          push, pop;

   // Entry storage carries no reset: occupancy comes from the pointers only.
   logic [AW-1:0] dr_mem   [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];

   logic [PW-1:0]            slot_off [DEPTH];
   logic [DEPTH-1:0]         slot_valid;
   logic [DEPTH-1:0][AW-1:0] slot_dr;
`ifdef MIPS_WB_FWD_EN
   logic [DEPTH-1:0][DW-1:0] slot_data;
`endif

   // No pass-through when full: in_ready depends only on registered level.
   assign in_ready = (level_reg < LW'(DEPTH));
   // A result for register 0 is acknowledged but never stored.
   assign push     = in_valid && in_ready && (in_dr != '0);
   assign pop      = (level_reg != '0) && !wb_stall;

   assign write    = pop;
   assign dr       = (level_reg != '0) ? dr_mem[head_reg]   : '0;
   assign wrData   = (level_reg != '0) ? data_mem[head_reg] : '0;
   assign level    = level_reg;

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      level_next = level_reg;
      if (push) begin
         tail_next = tail_reg + PW'(1);
      end
      if (pop) begin
         head_next = head_reg + PW'(1);
      end
      if (push && !pop) begin
         level_next = level_reg + LW'(1);
      end else if (pop && !push) begin
         level_next = level_reg - LW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         level_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         level_reg <= level_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         dr_mem[tail_reg]   <= in_dr;
         data_mem[tail_reg] <= in_data;
      end
   end

   // A slot is occupied when its distance from head (mod DEPTH) is below level.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         assign slot_off[gi]   = PW'(gi) - head_reg;
         assign slot_valid[gi] = ({1'b0, slot_off[gi]} < level_reg);
         assign slot_dr[gi]    = dr_mem[gi];
`ifdef MIPS_WB_FWD_EN
         assign slot_data[gi]  = data_mem[gi];
`endif
      end
   endgenerate

   mips_wb_match #(
      .AW    (AW),
      .DEPTH (DEPTH)
`ifdef MIPS_WB_FWD_EN
      ,
      .DW    (DW)
`endif
   ) u_match1 (
      .slot_valid (slot_valid),
      .head       (head_reg),
      .slot_dr    (slot_dr),
`ifdef MIPS_WB_FWD_EN
      .slot_data  (slot_data),
      .fwd        (fwd1),
`endif
      .sr         (sr1),
      .hit        (hit1)
   );

   mips_wb_match #(
      .AW    (AW),
      .DEPTH (DEPTH)
`ifdef MIPS_WB_FWD_EN
      ,
      .DW    (DW)
`endif
   ) u_match2 (
      .slot_valid (slot_valid),
      .head       (head_reg),
      .slot_dr    (slot_dr),
`ifdef MIPS_WB_FWD_EN
      .slot_data  (slot_data),
      .fwd        (fwd2),
`endif
      .sr         (sr2),
      .hit        (hit2)
   );

endmodule
